// File: rtl/seg7_pkg.sv
// Shared constants and payload types for the multiplexed 7-segment display stage.
package seg7_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first; 'b' and 'd' are lowercase.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              zf;
    logic              ovf;
  } shadow_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low a-g segment pattern.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan.sv
// Captures ALU result and flags on a load edge and scans them as eight hex digits
// on a common-anode display with a blank gap, leading-zero suppression and flag dps.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              zf_in,
  input  logic              of_in,
  input  logic              load,
  input  logic              lz_blank,
  output logic [7:0]        seg,
  output logic [7:0]        an,
  output logic              busy
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             load_q;
  logic             cap_c;
  shadow_t          shadow_q;
  shadow_t          eff_c;
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       digit;
  logic             wrap_c;
  logic [3:0]       nib_c;
  logic [6:0]       hex_c;
  logic [DIGITS-1:0] blank_c;
  logic             zero_run;
  logic             dp_n_c;
  logic [7:0]       seg_word_c;

  hex7seg u_hex (
    .nib   (nib_c),
    .seg_c (hex_c)
  );

  // A capture coinciding with slot start must already be visible in that slot.
  always_comb begin
    cap_c  = load & ~load_q;
    wrap_c = (div_cnt == CNT_W'(DIV - 1));
    eff_c  = cap_c ? shadow_t'{value: data_in, zf: zf_in, ovf: of_in} : shadow_q;
    nib_c  = 4'(eff_c.value >> {digit, 2'b00});

    blank_c  = '0;
    zero_run = lz_blank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (eff_c.value[4*i +: 4] == 4'h0);
      blank_c[i] = zero_run;
    end

    case (digit)
      3'd0:    dp_n_c = ~eff_c.ovf;
      3'd1:    dp_n_c = ~eff_c.zf;
      default: dp_n_c = 1'b1;
    endcase

    seg_word_c = {dp_n_c, blank_c[digit] ? SEG_OFF : hex_c};
  end

  // Edge detect and shadow; load_q resets high so a held load does not capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q   <= 1'b1;
      busy     <= 1'b0;
      shadow_q <= '0;
    end else begin
      load_q <= load;
      busy   <= cap_c;
      if (cap_c) shadow_q <= shadow_t'{value: data_in, zf: zf_in, ovf: of_in};
    end
  end

  // Slot timing; segment word latched once per slot so updates never tear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      digit   <= '0;
      seg     <= {1'b1, SEG_OFF};
      an      <= AN_OFF;
    end else begin
      div_cnt <= wrap_c ? '0 : div_cnt + CNT_W'(1);
      if (wrap_c) digit <= digit + 3'd1;
      if (div_cnt == '0) seg <= seg_word_c;
      an <= (div_cnt < CNT_W'(BLANK)) ? AN_OFF : ~(8'h01 << digit);
    end
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Downstream display stage for the stepped CPU. It captures the 32-bit ALU result and the ZF/OF flags when the debounced step pulse rises, then shows the value as eight hex digits on a multiplexed, common-anode 7-segment display. Scanning is time-multiplexed with an anti-ghosting blank gap, optional leading-zero suppression, and the flags mapped onto decimal points. It sits beside the CPU at top level and replaces the 8-LED byte viewer.

## Interface
- `DIV`, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
- `BLANK`, 1000: cycles at the start of each slot with all anodes off; must be < `DIV`.
- `clk` in 1: system clock (100 MHz on board).
- `rst` in 1: reset; asynchronous, active-low.
- `data_in` in 32: value to display (ALU result).
- `zf_in` in 1: zero flag to display.
- `of_in` in 1: overflow flag to display.
- `load` in 1: capture request, level. May stay high for many cycles; only its rising edge matters.
- `lz_blank` in 1: 1 = suppress leading zero digits.
- `seg` out 8: {dp,g,f,e,d,c,b,a}, active-low.
- `an` out 8: digit anodes, active-low; bit 0 is the rightmost digit.
- `busy` out 1: high for the one cycle in which the shadow register updates.

## Operation
- **Capture**
  - `load` is registered once to `load_q`.
  - `cap = load & ~load_q`.
  - On `cap`, the shadow registers take `data_in`, `zf_in` and `of_in`. `busy` is asserted in that same cycle.
  - Capture does not disturb the scan position.
- **Scan**
  - `div_cnt` counts 0..DIV-1, then wraps to 0.
  - `digit` (3 bits) increments on each wrap. It wraps from 7 to 0.
- **Nibble and decode**
  - The displayed nibble is `shadow[4*digit+3 : 4*digit]`.
  - The hex decoder drives 0-F using the standard a-g patterns. 'b' and 'd' are lowercase.
- **Decimal points**
  - dp lit on digit 0 iff `of`.
  - dp lit on digit 1 iff `zf`.
  - dp dark on all other digits.
- **Leading-zero blanking**
  - Applies when `lz_blank`=1.
  - A digit is blank (segments a-g off) if it and every higher digit are zero.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - The dp of a blanked digit still follows the flag rule.
- **Anodes**
  - While `div_cnt < BLANK`: `an` = 8'hFF.
  - Otherwise: `an` = ~(1 << digit).
- **Output registers**
  - `seg` and `an` are registered and computed from the current `digit`/`div_cnt`.
  - A shadow update appears on the next displayed digit with no tearing inside a slot, because the segment word is sampled at slot start.

## Timing
- **Reset values**
  - Reset (low) is asynchronous.
  - `an`=8'hFF, `seg`=8'hFF, `busy`=0, `shadow`=0, flags=0, `digit`=0, `div_cnt`=0.
  - `load_q`=1, so a `load` already high at reset release does not capture.
- **Capture latency**
  - `load` rises in cycle N, then `busy`=1 in cycle N+1 and the shadow is valid from cycle N+1.
- **Slot segment word**
  - Latched when `div_cnt`==0.
  - `an`/`seg` outputs lag the counter by 1 cycle.
- **Full refresh period**
  - 8*DIV cycles.
  - Each anode is low for DIV-BLANK consecutive cycles per period.
  - Never more than one anode low at a time.
- **Simultaneous events**
  - If `cap` coincides with `div_cnt`==0, the new value is used for that slot.
- **Reset mid-slot**
  - All anodes go off immediately.
  - Scanning restarts at digit 0 after release.

## Structure
- Package `seg7_pkg`:
  - 16-entry segment pattern constants (active-low a-g).
  - `SEG_OFF` = 7'h7F.
  - `AN_OFF` = 8'hFF.
- One sub-module, `hex7seg`: combinational nibble → 7-bit active-low pattern.
- Everything else (edge detect, shadow, counters, blanking mask, output registers) lives in `seg7_scan`.

## Test plan
Run with DIV=16 and BLANK=2.
- **Reset:** hold `rst`=0 with `load`=1 and `data_in`=32'h12345678, then release → `an`=8'hFF for cycles 0-2 and shadow stays 0. Digit 0 shows "0" (`seg`=8'hC0); all other digits blank with `lz_blank`=1 and show "0" with `lz_blank`=0.
- **Capture:** pulse `load` for 40 cycles with `data_in`=32'hDEADBEEF → exactly one `busy` cycle. Over 128 cycles the digits show F,E,E,B,D,A,E,D from digit 0 up ("E" = 8'h86, "d" = 8'hA1).
- **Flags:** `data_in`=0, `zf_in`=1, `of_in`=1, capture → digit 0 `seg`=8'h40 and digit 1 dp low. With `lz_blank`=1, digit 1 `seg`=8'h7F. All other digits have dp high.
- **Leading-zero blanking:** `data_in`=32'h00000A00, `lz_blank`=1 → digits 7..3 `seg`=8'hFF. Digit 2 shows 8'h88 ("A"); digits 1 and 0 show "0".
- **Anti-ghosting and exclusivity:** assert that `an` is never other than one-cold or all-ones. Each slot has exactly 2 cycles of 8'hFF before the anode goes low.
- **Reset mid-slot:** drive `rst` low at `div_cnt`=9 of digit 5 → `an`=8'hFF with no clock edge. After release the first active anode is 8'hFE.
